// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizes for the SRAM bank controller.
// Widths match the sky130 32x256 macro; they are not meant to be changed independently.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W  = 8;
  localparam int SRAM_DATA_W  = 32;
  localparam int SRAM_MASK_W  = 4;
  localparam int SRAM_DEPTH   = 256;
  localparam int RSP_DEPTH    = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic                   we;
    logic [SRAM_MASK_W-1:0] wmask;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO that holds captured read data until the requester takes it.
// Storage resets to zero so the head reads as 0 straight out of reset.
module sram_rsp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// Request/response front end for one sky130 32x256 SRAM macro: zero-fills the array
// after reset, then turns valid/ready requests into port-0 accesses with buffered reads.
module sram_bank_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int ADDR_W         = SRAM_ADDR_W,
  parameter int DATA_W         = SRAM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [3:0]        req_wmask_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              init_done_o,
  output logic              sram_clk0_o,
  output logic              sram_csb0_o,
  output logic              sram_web0_o,
  output logic [3:0]        sram_wmask0_o,
  output logic [ADDR_W-1:0] sram_addr0_o,
  output logic [DATA_W-1:0] sram_din0_o,
  input  logic [DATA_W-1:0] sram_dout0_i,
  output logic              sram_clk1_o,
  output logic              sram_csb1_o,
  output logic [ADDR_W-1:0] sram_addr1_o
);

  // state | meaning
  // INIT  | zero-fill sweep, one full-word write per cycle, requests blocked
  // RUN   | serve requests; reads return through the response FIFO

  state_e            state;
  state_e            state_next;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] init_cnt_next;
  logic              inflight;
  logic              accept;
  logic              rd_accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [2:0]        credit_used;
  sram_req_t         req;

  assign req = '{we: req_we_i, wmask: req_wmask_i, addr: req_addr_i, wdata: req_wdata_i};

  assign sram_clk0_o  = clk_i;
  assign sram_clk1_o  = clk_i;
  assign sram_csb1_o  = 1'b1;
  assign sram_addr1_o = '0;

  assign init_done_o = (state == RUN);
  assign rsp_valid_o = !fifo_empty;
  assign pop         = rsp_valid_o && rsp_ready_i;

  // A slot freed by this cycle's pop is reusable immediately; without that credit a
  // steady read stream with a ready consumer would stall every other cycle.
  assign credit_used = 3'(fifo_count) + 3'(inflight) - 3'(pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      if (CLEAR_ON_RESET) begin
        state <= INIT;
      end else begin
        state <= RUN;
      end
      init_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
      inflight <= rd_accept;
    end
  end

  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    req_ready_o   = 1'b0;
    accept        = 1'b0;
    rd_accept     = 1'b0;
    sram_csb0_o   = 1'b1;
    sram_web0_o   = 1'b0;
    sram_wmask0_o = '0;
    sram_addr0_o  = '0;
    sram_din0_o   = '0;

    case (state)
      INIT: begin
        sram_csb0_o   = 1'b0;
        sram_web0_o   = 1'b0;
        sram_wmask0_o = 4'hF;
        sram_addr0_o  = init_cnt;
        if (init_cnt == ADDR_W'(SRAM_DEPTH-1)) begin
          state_next = RUN;
        end else begin
          init_cnt_next = init_cnt + 1'b1;
        end
      end

      RUN: begin
        req_ready_o = (credit_used < 3'(RSP_DEPTH));
        accept      = req_valid_i && req_ready_o;
        rd_accept   = accept && !req.we;
        if (accept) begin
          sram_csb0_o  = 1'b0;
          sram_web0_o  = !req.we;
          sram_addr0_o = req.addr;
          if (req.we) begin
            sram_wmask0_o = req.wmask;
            sram_din0_o   = req.wdata;
          end
        end
      end

      default: state_next = INIT;
    endcase
  end

  sram_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (inflight),
    .pop   (pop),
    .din   (sram_dout0_i),
    .dout  (rsp_rdata_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Capture arriving at a full buffer with nothing leaving would lose read data.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(inflight && fifo_full && !pop));

endmodule
